// File: rtl/axil_read_arbiter.sv
// axil_read_arbiter
//   Round-robin arbiter that shares one AXI4-Lite read channel among NUM_REQ
//   read kernels. Only one read is outstanding at a time. Each kernel supplies
//   a word index, which is converted to a byte address (index << 2).
//
// Ports
//   clk, rst           clock (rising edge); asynchronous active-low reset
//   req_valid/ready    per-requester request handshake (ready is one-hot)
//   req_addr           per-requester word index, slice i = [32*i+31:32*i]
//   resp_valid         one-hot, one-cycle response strobe
//   resp_data/err      shared read data and error flag, held until next capture
//   busy, grant_id     status: not idle / current or last granted requester
//   s_axil_ar*/r*      AXI4-Lite read address and read data channels
//   state_dbg          FSM state (IDLE=0, ADDR=1, DATA=2, RESP=3)
//
// Handshake semantics: every channel transfers on the cycle where valid and
// ready are both high at the rising clock edge. The source holds valid and its
// payload stable until the transfer. req_ready depends on req_valid in the
// same cycle; all other outputs come from registers or from the state.
module axil_read_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*32-1:0]   req_addr,
  output logic [NUM_REQ-1:0]      resp_valid,
  output logic [DATA_WIDTH-1:0]   resp_data,
  output logic                    resp_err,
  output logic                    busy,
  output logic [2:0]              grant_id,
  output logic [ADDR_WIDTH-1:0]   s_axil_araddr,
  output logic [2:0]              s_axil_arprot,
  output logic                    s_axil_arvalid,
  input  logic                    s_axil_arready,
  input  logic [DATA_WIDTH-1:0]   s_axil_rdata,
  input  logic [1:0]              s_axil_rresp,
  input  logic                    s_axil_rvalid,
  output logic                    s_axil_rready,
  output logic [1:0]              state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [2:0]              last_grant_q;
  logic [2:0]              grant_id_q;
  logic [ADDR_WIDTH-1:0]   araddr_q;
  logic [DATA_WIDTH-1:0]   resp_data_q;
  logic                    resp_err_q;

  logic                    win_found;
  logic [2:0]              win_idx;
  logic [ADDR_WIDTH-1:0]   araddr_d;
  logic                    accept;
  logic                    capture;

  // Round-robin search starting one past the last winner, wrapping at NUM_REQ.
  always_comb begin
    int cand;
    cand      = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = (int'(last_grant_q) + off) % NUM_REQ;
      if (!win_found && 1'(req_valid >> cand)) begin
        win_found = 1'b1;
        win_idx   = 3'(cand);
      end
    end
  end

  // Word index to byte address; index bits above ADDR_WIDTH-3 are dropped.
  assign araddr_d = {(ADDR_WIDTH-2)'(req_addr >> (32 * win_idx)), 2'b00};

  assign accept  = (state_q == IDLE) && win_found;
  assign capture = (state_q == DATA) && s_axil_rvalid;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_found)      state_d = ADDR;
      ADDR:    if (s_axil_arready) state_d = DATA;
      DATA:    if (s_axil_rvalid)  state_d = RESP;
      RESP:                        state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= 3'(NUM_REQ - 1);
      grant_id_q   <= '0;
      araddr_q     <= '0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        last_grant_q <= win_idx;
        grant_id_q   <= win_idx;
        araddr_q     <= araddr_d;
      end
      if (capture) begin
        resp_data_q <= s_axil_rdata;
        resp_err_q  <= |s_axil_rresp;
      end
    end
  end

  assign req_ready      = accept ? (NUM_REQ'(1) << win_idx) : '0;
  assign resp_valid     = (state_q == RESP) ? (NUM_REQ'(1) << grant_id_q) : '0;
  assign resp_data      = resp_data_q;
  assign resp_err       = resp_err_q;
  assign busy           = (state_q != IDLE);
  assign grant_id       = grant_id_q;
  assign s_axil_araddr  = araddr_q;
  assign s_axil_arprot  = 3'b000;
  assign s_axil_arvalid = (state_q == ADDR);
  assign s_axil_rready  = (state_q == DATA);
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_axil_read_arbiter.sv
// Directed testbench for axil_read_arbiter (NUM_REQ=4, ADDR_WIDTH=16,
// DATA_WIDTH=32). The bench plays the AXI-Lite slave by driving arready,
// rvalid, rdata and rresp directly in each step.
module tb_axil_read_arbiter;

  localparam int NR = 4;
  localparam int AW = 16;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NR-1:0]     req_valid = '0;
  logic [NR-1:0]     req_ready;
  logic [NR*32-1:0]  req_addr = '0;
  logic [NR-1:0]     resp_valid;
  logic [DW-1:0]     resp_data;
  logic              resp_err;
  logic              busy;
  logic [2:0]        grant_id;
  logic [AW-1:0]     araddr;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready = 1'b0;
  logic [DW-1:0]     rdata = '0;
  logic [1:0]        rresp = '0;
  logic              rvalid = 1'b0;
  logic              rready;
  logic [1:0]        state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  axil_read_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .resp_valid     (resp_valid),
    .resp_data      (resp_data),
    .resp_err       (resp_err),
    .busy           (busy),
    .grant_id       (grant_id),
    .s_axil_araddr  (araddr),
    .s_axil_arprot  (arprot),
    .s_axil_arvalid (arvalid),
    .s_axil_arready (arready),
    .s_axil_rdata   (rdata),
    .s_axil_rresp   (rresp),
    .s_axil_rvalid  (rvalid),
    .s_axil_rready  (rready),
    .state_dbg      (state_dbg)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Protocol invariants checked every cycle outside reset.
  always @(negedge clk) begin
    if (rst) begin
      chk("ar_r_overlap", {63'd0, arvalid & rready}, 64'd0);
      chk("ready_onehot0", {63'd0, $onehot0(req_ready)}, 64'd1);
    end
  end

  initial begin
    logic [3:0] oh;

    // ---------------- reset ----------------
    rst = 1'b0;
    step(); step();
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_arvalid", {63'd0, arvalid}, 64'd0);
    chk("rst_rready", {63'd0, rready}, 64'd0);
    chk("rst_resp_valid", {60'd0, resp_valid}, 64'd0);
    chk("rst_grant_id", {61'd0, grant_id}, 64'd0);
    chk("rst_araddr", {48'd0, araddr}, 64'd0);
    chk("rst_resp_data", {32'd0, resp_data}, 64'd0);
    chk("rst_arprot", {61'd0, arprot}, 64'd0);
    rst = 1'b1;
    step();
    chk("idle_no_req_ready", {60'd0, req_ready}, 64'd0);

    // ---------------- single read: req 0, index 5 ----------------
    req_addr[31:0] = 32'd5;
    req_valid = 4'b0001;
    arready = 1'b1; rvalid = 1'b1; rdata = 32'hDEAD_BEEF; rresp = 2'b00;
    #1;
    chk("t1_req_ready", {60'd0, req_ready}, 64'h1);
    step();                                  // cycle 1: ADDR
    req_valid = '0;
    chk("t1_arvalid", {63'd0, arvalid}, 64'd1);
    chk("t1_araddr", {48'd0, araddr}, 64'h14);
    chk("t1_busy", {63'd0, busy}, 64'd1);
    step();                                  // cycle 2: DATA
    chk("t1_rready", {63'd0, rready}, 64'd1);
    step();                                  // cycle 3: RESP
    chk("t1_resp_valid", {60'd0, resp_valid}, 64'h1);
    chk("t1_resp_data", {32'd0, resp_data}, 64'hDEAD_BEEF);
    chk("t1_resp_err", {63'd0, resp_err}, 64'd0);
    step();                                  // back to IDLE
    chk("t1_resp_done", {60'd0, resp_valid}, 64'd0);
    chk("t1_idle", {63'd0, busy}, 64'd0);
    chk("t1_data_hold", {32'd0, resp_data}, 64'hDEAD_BEEF);

    // ---------------- all four requesting from reset ----------------
    rst = 1'b0;
    step();
    rst = 1'b1;
    for (int i = 0; i < NR; i++) req_addr[32*i +: 32] = 32'(i + 8);
    req_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      int exp_g;
      exp_g = k % 4;
      oh = 4'b0001 << exp_g;
      rdata = 32'h100 + 32'(k);
      #1;
      chk("t2_req_ready", {60'd0, req_ready}, {60'd0, oh});
      step();
      chk("t2_grant_id", {61'd0, grant_id}, 64'(exp_g));
      chk("t2_araddr", {48'd0, araddr}, 64'((exp_g + 8) * 4));
      step();
      step();
      chk("t2_resp_valid", {60'd0, resp_valid}, {60'd0, oh});
      chk("t2_resp_data", {32'd0, resp_data}, 64'h100 + 64'(k));
      step();
    end
    req_valid = '0;
    step();

    // ---------------- slave stalls: req 1, index 0x3FFF ----------------
    req_addr[63:32] = 32'h3FFF;
    req_valid = 4'b0010;
    arready = 1'b0; rvalid = 1'b0;
    #1;
    chk("t3_req_ready", {60'd0, req_ready}, 64'h2);
    step();
    req_valid = '0;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) arready = 1'b1;
      #1;
      chk("t3_arvalid_hold", {63'd0, arvalid}, 64'd1);
      chk("t3_araddr_hold", {48'd0, araddr}, 64'hFFFC);
      chk("t3_no_rready", {63'd0, rready}, 64'd0);
      step();
    end
    arready = 1'b0;
    rdata = 32'h1234_5678;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) rvalid = 1'b1;
      #1;
      chk("t3_rready_hold", {63'd0, rready}, 64'd1);
      chk("t3_no_arvalid", {63'd0, arvalid}, 64'd0);
      step();
    end
    rvalid = 1'b0;
    chk("t3_resp_valid", {60'd0, resp_valid}, 64'h2);
    chk("t3_resp_data", {32'd0, resp_data}, 64'h1234_5678);
    step();

    // ---------------- error and truncation: req 2 ----------------
    req_addr[95:64] = 32'h0001_4003;
    req_valid = 4'b0100;
    arready = 1'b1; rvalid = 1'b1; rresp = 2'b10; rdata = 32'hE0E0_E0E0;
    #1;
    chk("t4_req_ready", {60'd0, req_ready}, 64'h4);
    step();
    req_valid = '0;
    chk("t4_araddr", {48'd0, araddr}, 64'h000C);
    step();
    step();
    chk("t4_resp_valid", {60'd0, resp_valid}, 64'h4);
    chk("t4_resp_err", {63'd0, resp_err}, 64'd1);
    step();
    rresp = 2'b00;

    // ---------------- stray rvalid in IDLE and ADDR ----------------
    arready = 1'b0; rvalid = 1'b1; rdata = 32'h0000_0BAD;
    #1;
    chk("t6_idle_rready", {63'd0, rready}, 64'd0);
    step();
    chk("t6_idle_nocap", {32'd0, resp_data}, 64'hE0E0_E0E0);
    req_addr[31:0] = 32'h7;
    req_valid = 4'b0001;
    step();                                  // ADDR, arready low
    req_valid = '0;
    chk("t6_addr_rready", {63'd0, rready}, 64'd0);
    step();
    chk("t6_addr_nocap", {32'd0, resp_data}, 64'hE0E0_E0E0);
    chk("t6_addr_err_hold", {63'd0, resp_err}, 64'd1);
    arready = 1'b1; rdata = 32'h55;
    step();                                  // DATA
    step();                                  // RESP
    chk("t6_resp_data", {32'd0, resp_data}, 64'h55);
    chk("t6_resp_valid", {60'd0, resp_valid}, 64'h1);
    step();

    // ---------------- reset mid-DATA: req 3 ----------------
    req_addr[127:96] = 32'h20;
    req_valid = 4'b1000;
    arready = 1'b1; rvalid = 1'b0;
    step();                                  // ADDR
    req_valid = '0;
    step();                                  // DATA
    chk("t5_in_data", {63'd0, rready}, 64'd1);
    rst = 1'b0;
    #1;
    chk("t5_async_rready", {63'd0, rready}, 64'd0);
    chk("t5_async_busy", {63'd0, busy}, 64'd0);
    chk("t5_async_resp", {60'd0, resp_valid}, 64'd0);
    chk("t5_async_data", {32'd0, resp_data}, 64'd0);
    rvalid = 1'b1;
    step();
    chk("t5_no_pulse", {60'd0, resp_valid}, 64'd0);
    rst = 1'b1;
    req_addr[63:32] = 32'h9;
    req_valid = 4'b1010;
    #1;
    chk("t5_first_req1", {60'd0, req_ready}, 64'h2);
    step();
    req_valid = 4'b1000;
    chk("t5_grant1", {61'd0, grant_id}, 64'd1);
    chk("t5_araddr1", {48'd0, araddr}, 64'h24);
    step();
    step();
    chk("t5_resp1", {60'd0, resp_valid}, 64'h2);
    step();
    chk("t5_next_req3", {60'd0, req_ready}, 64'h8);
    step();
    req_valid = '0;
    chk("t5_grant3", {61'd0, grant_id}, 64'd3);
    chk("t5_araddr3", {48'd0, araddr}, 64'h80);
    step();
    step();
    chk("t5_resp3", {60'd0, resp_valid}, 64'h8);
    step();
    rvalid = 1'b0; arready = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
